hms_display: RTL and testbench

HMS_DISPLAY -- requirements
Module: hms_display

---
 rtl/hms_display.sv | 168 ++++++++++++++++
 tb/tb_hms_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hms_display.sv
// hms_display: converts a binary {hrs, min, sec} time into six BCD digits on
// every half_sec_pulse, then time-multiplexes them onto a 6-digit
// active-low 7-segment display, with a blinking colon on the decimal points.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   HMS_time       {hrs[18:12], min[11:6], sec[5:0]} binary
//   half_sec_pulse one-cycle refresh strobe (also toggles the colon)
//   blank          turns all digit enables off while high
//   seg            active-low segments, seg[0]=a .. seg[6]=g
//   dp             active-low decimal point (colon)
//   an             active-low one-hot digit enable, an[5]=hours tens
//   bcd            six BCD digits, bcd[23:20]=hours tens
//   busy           conversion in progress
module hms_display #(
  parameter int SCAN_DIV = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [18:0] HMS_time,
  input  logic        half_sec_pulse,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic [23:0] bcd,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, HRS, MIN, SEC, DONE} state_t;

  state_t      state;
  logic        pending;
  logic        colon;
  logic [14:0] sh;        // {tens, ones, binary} double-dabble register
  logic [2:0]  iter;
  logic [5:0]  min_v, sec_v;
  logic [7:0]  hr_bcd, mn_bcd;
  logic [15:0] scan_cnt;
  logic [2:0]  idx;

  // One shift-add-3 step; max value 99 so the top bit never overflows.
  function automatic logic [14:0] dd_step(input logic [14:0] s);
    logic [14:0] t;
    t = s;
    if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7F;
    endcase
  endfunction

  logic [14:0] sh_nx;
  logic [6:0]  h_sat;
  logic [5:0]  m_sat, s_sat;

  assign sh_nx = dd_step(sh);
  assign h_sat = (HMS_time[18:12] > 7'd99) ? 7'd99 : HMS_time[18:12];
  assign m_sat = (HMS_time[11:6]  > 6'd59) ? 6'd59 : HMS_time[11:6];
  assign s_sat = (HMS_time[5:0]   > 6'd59) ? 6'd59 : HMS_time[5:0];

  // Conversion FSM. busy rises on the LOAD edge and falls on the DONE edge,
  // which fixes the latency at 23 edges after the sampling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      busy    <= 1'b0;
      bcd     <= '0;
      sh      <= '0;
      iter    <= '0;
      min_v   <= '0;
      sec_v   <= '0;
      hr_bcd  <= '0;
      mn_bcd  <= '0;
    end else begin
      case (state)
        IDLE: if (half_sec_pulse || pending) state <= LOAD;
        LOAD: begin
          sh    <= {8'd0, h_sat};
          min_v <= m_sat;
          sec_v <= s_sat;
          iter  <= '0;
          busy  <= 1'b1;
          state <= HRS;
        end
        HRS: begin
          sh   <= sh_nx;
          iter <= iter + 3'd1;
          if (iter == 3'd6) begin
            hr_bcd <= sh_nx[14:7];
            sh     <= {9'd0, min_v};
            iter   <= '0;
            state  <= MIN;
          end
        end
        MIN: begin
          sh   <= sh_nx;
          iter <= iter + 3'd1;
          if (iter == 3'd6) begin
            mn_bcd <= sh_nx[14:7];
            sh     <= {9'd0, sec_v};
            iter   <= '0;
            state  <= SEC;
          end
        end
        SEC: begin
          // Seconds result is left in sh[14:7] for DONE.
          sh   <= sh_nx;
          iter <= iter + 3'd1;
          if (iter == 3'd6) state <= DONE;
        end
        DONE: begin
          bcd   <= {hr_bcd, mn_bcd, sh[14:7]};
          busy  <= 1'b0;
          state <= pending ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase

      // One-deep request queue; a pulse seen outside IDLE is remembered once.
      if (half_sec_pulse && state != IDLE && !pending) pending <= 1'b1;
      else if (state == DONE || state == IDLE)           pending <= 1'b0;
    end
  end

  // Colon toggle, scan divider and registered display drive.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      colon    <= 1'b0;
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      an       <= 6'h3F;
    end else begin
      if (half_sec_pulse) colon <= ~colon;

      if (scan_cnt == 16'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end

      if (idx == 3'd5 && bcd[23:20] == 4'd0) seg <= 7'h7F;
      else                                    seg <= seg_dec(bcd[idx*4 +: 4]);
      an <= blank ? 6'h3F : ~(6'd1 << idx);
      dp <= blank | ~((idx == 3'd4 || idx == 3'd2) & colon);
    end
  end

endmodule

// File: tb/tb_hms_display.sv
// Self-checking bench for hms_display (SCAN_DIV=4): vector table of
// conversions with scan/segment checks after each, plus back-to-back pulses,
// blanking, and reset in the middle of a conversion.
module tb_hms_display;

  localparam int SD = 4;

  logic        clock, reset, half_sec_pulse, blank;
  logic [18:0] HMS_time;
  logic [6:0]  seg;
  logic        dp, busy;
  logic [5:0]  an;
  logic [23:0] bcd;

  hms_display #(.SCAN_DIV(SD)) dut (
    .clock(clock), .reset(reset), .HMS_time(HMS_time),
    .half_sec_pulse(half_sec_pulse), .blank(blank),
    .seg(seg), .dp(dp), .an(an), .bcd(bcd), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges since reset release; an after edge n shows digit ((n-1)/SD)%6.
  int ecnt;
  always @(posedge clock or negedge reset)
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  int checks = 0;
  int errors = 0;
  logic [23:0] cur_bcd;
  logic        colon_exp;

  typedef struct {
    logic [6:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] segx(input logic [3:0] d);
    case (d)
      4'd0: segx = 7'h40; 4'd1: segx = 7'h79; 4'd2: segx = 7'h24;
      4'd3: segx = 7'h30; 4'd4: segx = 7'h19; 4'd5: segx = 7'h12;
      4'd6: segx = 7'h02; 4'd7: segx = 7'h78; 4'd8: segx = 7'h00;
      4'd9: segx = 7'h10; default: segx = 7'h7F;
    endcase
  endfunction

  task automatic check_scan(input int n);
    int idx;
    logic [3:0] d;
    logic [6:0] es;
    logic [5:0] ea;
    for (int i = 0; i < n; i++) begin
      tick(1);
      idx = ((ecnt - 1) / SD) % 6;
      ea  = ~(6'd1 << idx);
      d   = cur_bcd[idx*4 +: 4];
      es  = (idx == 5 && d == 4'd0) ? 7'h7F : segx(d);
      chk("scan_an", {26'd0, an}, {26'd0, ea});
      chk("scan_seg", {25'd0, seg}, {25'd0, es});
      chk("scan_dp", {31'd0, dp}, {31'd0, ~((idx == 4 || idx == 2) && colon_exp)});
    end
  endtask

  task automatic pulse();
    half_sec_pulse = 1'b1;
    tick(1);
    half_sec_pulse = 1'b0;
    colon_exp = ~colon_exp;
  endtask

  task automatic run_vec(input vec_t v);
    HMS_time = {v.h, v.m, v.s};
    pulse();
    chk("busy_e0", {31'd0, busy}, 32'd0);
    tick(1);
    chk("busy_e1", {31'd0, busy}, 32'd1);
    tick(21);
    chk("busy_e22", {31'd0, busy}, 32'd1);
    chk("bcd_e22_old", {8'd0, bcd}, {8'd0, cur_bcd});
    tick(1);
    chk("busy_e23", {31'd0, busy}, 32'd0);
    chk("bcd_e23", {8'd0, bcd}, {8'd0, v.exp});
    cur_bcd = v.exp;
  endtask

  initial begin
    vecs[0] = '{7'd12,  6'd34, 6'd56, 24'h123456};
    vecs[1] = '{7'd127, 6'd63, 6'd5,  24'h995905};
    vecs[2] = '{7'd5,   6'd0,  6'd0,  24'h050000};
    vecs[3] = '{7'd99,  6'd59, 6'd59, 24'h995959};
    vecs[4] = '{7'd100, 6'd60, 6'd60, 24'h995959};
    vecs[5] = '{7'd0,   6'd0,  6'd0,  24'h000000};
    vecs[6] = '{7'd9,   6'd9,  6'd9,  24'h090909};
    vecs[7] = '{7'd10,  6'd10, 6'd10, 24'h101010};
    vecs[8] = '{7'd23,  6'd47, 6'd18, 24'h234718};

    reset = 1'b0; half_sec_pulse = 1'b0; blank = 1'b0; HMS_time = '0;
    cur_bcd = '0; colon_exp = 1'b0;
    tick(2);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_an", {26'd0, an}, 32'h3F);
    chk("rst_bcd", {8'd0, bcd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    check_scan(6 * SD + 1);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
      check_scan(6 * SD);
    end

    // Pulses at t, t+5, t+10: second is queued, third dropped.
    HMS_time = {7'd1, 6'd2, 6'd3};
    pulse();
    tick(4);
    HMS_time = {7'd45, 6'd6, 6'd7};
    pulse();
    tick(4);
    pulse();
    tick(13);
    chk("b2b_first_bcd", {8'd0, bcd}, 32'h010203);
    chk("b2b_first_busy", {31'd0, busy}, 32'd0);
    tick(1);
    chk("b2b_second_busy_start", {31'd0, busy}, 32'd1);
    tick(21);
    chk("b2b_second_busy_end", {31'd0, busy}, 32'd1);
    tick(1);
    chk("b2b_second_bcd", {8'd0, bcd}, 32'h450607);
    chk("b2b_second_busy_low", {31'd0, busy}, 32'd0);
    cur_bcd = 24'h450607;
    tick(30);
    chk("b2b_third_dropped_bcd", {8'd0, bcd}, 32'h450607);
    chk("b2b_third_dropped_busy", {31'd0, busy}, 32'd0);
    check_scan(6 * SD);

    // Flip colon and recheck dp placement.
    HMS_time = {7'd45, 6'd6, 6'd7};
    pulse();
    tick(25);
    check_scan(6 * SD);

    // Blanking: an off, dp off, scan phase continues underneath.
    blank = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("blank_an", {26'd0, an}, 32'h3F);
      chk("blank_dp", {31'd0, dp}, 32'd1);
    end
    blank = 1'b0;
    check_scan(6 * SD);

    // Reset in the middle of a conversion.
    HMS_time = {7'd12, 6'd34, 6'd56};
    pulse();
    tick(10);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_dp", {31'd0, dp}, 32'd1);
    chk("mid_rst_an", {26'd0, an}, 32'h3F);
    chk("mid_rst_bcd", {8'd0, bcd}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    reset = 1'b1;
    cur_bcd = '0; colon_exp = 1'b0;
    tick(30);
    chk("post_rst_bcd", {8'd0, bcd}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check_scan(6 * SD);
    run_vec(vecs[0]);
    check_scan(6 * SD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
